// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART command-frame parser: state encoding,
// frame constants and the frame checksum.
package uart_frame_parser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CHN  = 3'd1,
        ST_DHI  = 3'd2,
        ST_DLO  = 3'd3,
        ST_CSUM = 3'd4
    } state_e;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN      = 5;

    // The header byte is deliberately left out of the checksum.
    function automatic logic [7:0] frame_csum(input logic [7:0] chn,
                                              input logic [7:0] dhi,
                                              input logic [7:0] dlo);
        return chn ^ dhi ^ dlo;
    endfunction

endpackage

// File: rtl/uart_frame_parser_timeout_ctr.sv
// Idle-cycle counter with clear/enable and a terminal-count pulse; shared
// with the UART transmitter.
module frame_timeout_ctr #(
    parameter int unsigned LIMIT = 270000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over enable, so an arriving byte always beats the limit.
    assign tc_o = en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles 5-byte UART frames (header, channel, data hi, data lo, XOR
// checksum) into one-cycle command beats; bad or stalled frames are flagged.
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned CHN_WIDTH      = 3,
    parameter int unsigned NUM_CHN        = 4,
    parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 270000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  tr_valid_o,
    output logic [CHN_WIDTH-1:0]  tr_chn_o,
    output logic [DATA_WIDTH-1:0] tr_data_o,
    output logic                  err_crc_o,
    output logic                  err_chn_o,
    output logic                  err_to_o,
    output logic                  busy_o,
    output logic [15:0]           frame_cnt_o
);

    localparam logic [7:0] NUM_CHN_B = 8'(NUM_CHN);

    state_e     state_q, state_d;
    logic [7:0] chn_q, chn_d;
    logic [7:0] dhi_q, dhi_d;
    logic [7:0] dlo_q, dlo_d;
    logic       good_d, crc_bad_d, chn_bad_d;
    logic       to_clr, to_en, to_tc;

    logic                  tr_valid_q;
    logic [CHN_WIDTH-1:0]  tr_chn_q;
    logic [DATA_WIDTH-1:0] tr_data_q;
    logic                  err_crc_q, err_chn_q, err_to_q, busy_q;
    logic [15:0]           frame_cnt_q;

    // Counting only runs mid-frame on cycles without a byte.
    assign to_clr = rx_valid_i || (state_q == ST_IDLE);
    assign to_en  = !to_clr;

    frame_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr_i (to_clr),
        .en_i  (to_en),
        .tc_o  (to_tc)
    );

    always_comb begin
        state_d   = state_q;
        chn_d     = chn_q;
        dhi_d     = dhi_q;
        dlo_d     = dlo_q;
        good_d    = 1'b0;
        crc_bad_d = 1'b0;
        chn_bad_d = 1'b0;
        if (to_tc) begin
            state_d = ST_IDLE;
        end else if (rx_valid_i) begin
            case (state_q)
                ST_IDLE: if (rx_data_i == HEADER) state_d = ST_CHN;
                ST_CHN: begin
                    chn_d   = rx_data_i;
                    state_d = ST_DHI;
                end
                ST_DHI: begin
                    dhi_d   = rx_data_i;
                    state_d = ST_DLO;
                end
                ST_DLO: begin
                    dlo_d   = rx_data_i;
                    state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if (rx_data_i != frame_csum(chn_q, dhi_q, dlo_q)) begin
                        crc_bad_d = 1'b1;
                    end else if (chn_q >= NUM_CHN_B) begin
                        chn_bad_d = 1'b1;
                    end else begin
                        good_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            chn_q       <= '0;
            dhi_q       <= '0;
            dlo_q       <= '0;
            tr_valid_q  <= 1'b0;
            tr_chn_q    <= '0;
            tr_data_q   <= '0;
            err_crc_q   <= 1'b0;
            err_chn_q   <= 1'b0;
            err_to_q    <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            chn_q      <= chn_d;
            dhi_q      <= dhi_d;
            dlo_q      <= dlo_d;
            tr_valid_q <= good_d;
            err_crc_q  <= crc_bad_d;
            err_chn_q  <= chn_bad_d;
            err_to_q   <= to_tc;
            busy_q     <= (state_d != ST_IDLE);
            // Command outputs hold their last good value across error frames.
            if (good_d) begin
                tr_chn_q    <= chn_q[CHN_WIDTH-1:0];
                tr_data_q   <= DATA_WIDTH'({dhi_q, dlo_q});
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign tr_valid_o  = tr_valid_q;
    assign tr_chn_o    = tr_chn_q;
    assign tr_data_o   = tr_data_q;
    assign err_crc_o   = err_crc_q;
    assign err_chn_o   = err_chn_q;
    assign err_to_o    = err_to_q;
    assign busy_o      = busy_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: frame tasks push expected events, a monitor
// records what the parser emits, and each test task compares the two.
module tb_uart_frame_parser;

    localparam int TO_CYC = 16;
    localparam int CLK_P  = 10;
    localparam int EW     = 22;
    localparam logic [2:0] K_GOOD = 3'd1;
    localparam logic [2:0] K_CRC  = 3'd2;
    localparam logic [2:0] K_CHN  = 3'd3;
    localparam logic [2:0] K_TO   = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'h00;
    logic        tr_valid_o;
    logic [2:0]  tr_chn_o;
    logic [15:0] tr_data_o;
    logic        err_crc_o, err_chn_o, err_to_o, busy_o;
    logic [15:0] frame_cnt_o;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];
    time           obs_t_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [15:0]   exp_cnt = 16'd0;
    logic [2:0]    exp_chn = 3'd0;
    logic [15:0]   exp_data = 16'd0;
    time           t_last = 0;

    always #(CLK_P/2) clk = ~clk;

    uart_frame_parser #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .tr_valid_o  (tr_valid_o),
        .tr_chn_o    (tr_chn_o),
        .tr_data_o   (tr_data_o),
        .err_crc_o   (err_crc_o),
        .err_chn_o   (err_chn_o),
        .err_to_o    (err_to_o),
        .busy_o      (busy_o),
        .frame_cnt_o (frame_cnt_o)
    );

    // Every strobe becomes one event; overlapping strobes show up as extras.
    always @(negedge clk) begin
        if (tr_valid_o) begin obs_q.push_back({K_GOOD, tr_chn_o, tr_data_o}); obs_t_q.push_back($time); end
        if (err_crc_o)  begin obs_q.push_back({K_CRC, 19'd0}); obs_t_q.push_back($time); end
        if (err_chn_o)  begin obs_q.push_back({K_CHN, 19'd0}); obs_t_q.push_back($time); end
        if (err_to_o)   begin obs_q.push_back({K_TO, 19'd0}); obs_t_q.push_back($time); end
    end

    function automatic logic [EW-1:0] model_frame(input logic [7:0] c, input logic [7:0] h,
                                                  input logic [7:0] l, input logic [7:0] s);
        if (s != (c ^ h ^ l)) return {K_CRC, 19'd0};
        if (c >= 8'd4) return {K_CHN, 19'd0};
        return {K_GOOD, c[2:0], h, l};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] s);
        logic [EW-1:0] e;
        e = model_frame(c, h, l, s);
        exp_q.push_back(e);
        if (e[EW-1 -: 3] == K_GOOD) begin
            exp_cnt  = exp_cnt + 16'd1;
            exp_chn  = c[2:0];
            exp_data = {h, l};
        end
        send_byte(8'hA5);
        send_byte(c);
        send_byte(h);
        send_byte(l);
        t_last = $time;
        send_byte(s);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt  = 16'd0;
        exp_chn  = 3'd0;
        exp_data = 16'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (tr_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_tr_valid: got %b want 0", tr_valid_o); end
        vectors++; if (tr_chn_o !== 3'd0) begin miscompares++; $display("FAIL reset_tr_chn: got %0d want 0", tr_chn_o); end
        vectors++; if (tr_data_o !== 16'h0) begin miscompares++; $display("FAIL reset_tr_data: got %h want 0000", tr_data_o); end
        vectors++; if ({err_crc_o, err_chn_o, err_to_o} !== 3'b000) begin miscompares++; $display("FAIL reset_err: got %b want 000", {err_crc_o, err_chn_o, err_to_o}); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        vectors++; if (frame_cnt_o !== 16'h0) begin miscompares++; $display("FAIL reset_frame_cnt: got %h want 0000", frame_cnt_o); end
        rst = 1'b0;
        @(negedge clk);
        obs_q.delete(); obs_t_q.delete();
    endtask

    task automatic test_good_frame();
        logic [EW-1:0] e, o;
        send_frame(8'h02, 8'h12, 8'h34, 8'h24);
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++; $display("FAIL good_events: got %0d events want 1", obs_q.size());
        end else begin
            vectors++;
            if (obs_t_q[0] - t_last != CLK_P) begin miscompares++; $display("FAIL good_latency: got %0t want %0d", obs_t_q[0] - t_last, CLK_P); end
            e = exp_q[0]; o = obs_q[0];
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL good_beat: got %h want %h", o, e); end
        end
        vectors++; if (tr_data_o !== 16'h1234) begin miscompares++; $display("FAIL good_data: got %h want 1234", tr_data_o); end
        vectors++; if (frame_cnt_o !== exp_cnt) begin miscompares++; $display("FAIL good_cnt: got %0d want %0d", frame_cnt_o, exp_cnt); end
        exp_q.delete(); obs_q.delete(); obs_t_q.delete();
    endtask

    task automatic test_bad_crc();
        logic [EW-1:0] e, o;
        send_frame(8'h01, 8'h00, 8'h10, 8'h00);
        repeat (2) @(negedge clk);
        vectors++; if (tr_data_o !== exp_data) begin miscompares++; $display("FAIL crc_hold_data: got %h want %h", tr_data_o, exp_data); end
        vectors++; if (tr_chn_o !== exp_chn) begin miscompares++; $display("FAIL crc_hold_chn: got %0d want %0d", tr_chn_o, exp_chn); end
        send_frame(8'h01, 8'h00, 8'h10, 8'h11);
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL crc_events: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL crc_event: got %h want %h", o, e); end
        end
        vectors++; if (tr_data_o !== 16'h0010) begin miscompares++; $display("FAIL crc_next_data: got %h want 0010", tr_data_o); end
        vectors++; if (frame_cnt_o !== exp_cnt) begin miscompares++; $display("FAIL crc_cnt: got %0d want %0d", frame_cnt_o, exp_cnt); end
        exp_q.delete(); obs_q.delete(); obs_t_q.delete();
    endtask

    task automatic test_bad_chn_resync();
        logic [EW-1:0] e, o;
        send_frame(8'h05, 8'h00, 8'h01, 8'h04);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h17);
        send_frame(8'h03, 8'hFF, 8'h9C, 8'h60);
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL chn_events: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL chn_event: got %h want %h", o, e); end
        end
        vectors++; if ({tr_chn_o, tr_data_o} !== {3'd3, 16'hFF9C}) begin miscompares++; $display("FAIL chn_resync: got %0d/%h want 3/ff9c", tr_chn_o, tr_data_o); end
        exp_q.delete(); obs_q.delete(); obs_t_q.delete();
    endtask

    task automatic test_timeout();
        logic [EW-1:0] e, o;
        exp_q.push_back({K_TO, 19'd0});
        send_byte(8'hA5);
        send_byte(8'h00);
        repeat (5) @(negedge clk);
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL to_busy_mid: got %b want 1", busy_o); end
        repeat (TO_CYC - 5) @(negedge clk);
        @(negedge clk);
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL to_busy_after: got %b want 0", busy_o); end
        // A byte landing on the final allowed cycle must still be accepted.
        send_byte(8'hA5);
        send_byte(8'h00);
        repeat (TO_CYC - 1) @(negedge clk);
        exp_q.push_back(model_frame(8'h00, 8'h00, 8'h07, 8'h07));
        exp_cnt = exp_cnt + 16'd1; exp_chn = 3'd0; exp_data = 16'h0007;
        send_byte(8'h00);
        send_byte(8'h07);
        send_byte(8'h07);
        send_frame(8'h00, 8'h00, 8'h07, 8'h07);
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL to_events: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL to_event: got %h want %h", o, e); end
        end
        vectors++; if (frame_cnt_o !== exp_cnt) begin miscompares++; $display("FAIL to_cnt: got %0d want %0d", frame_cnt_o, exp_cnt); end
        exp_q.delete(); obs_q.delete(); obs_t_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [EW-1:0] e, o;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        pulse_reset();
        vectors++; if ({tr_chn_o, tr_data_o, frame_cnt_o, busy_o} !== 36'd0) begin miscompares++; $display("FAIL midrst_outputs: got %0d/%h/%h/%b want all 0", tr_chn_o, tr_data_o, frame_cnt_o, busy_o); end
        send_frame(8'h00, 8'h00, 8'h01, 8'h01);
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL midrst_events: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL midrst_event: got %h want %h", o, e); end
        end
        vectors++; if (frame_cnt_o !== 16'd1) begin miscompares++; $display("FAIL midrst_cnt: got %0d want 1", frame_cnt_o); end
        exp_q.delete(); obs_q.delete(); obs_t_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] e, o;
        logic [7:0] c, h, l;
        time t0;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            c = 8'($urandom_range(0, 3));
            h = 8'($urandom_range(0, 255));
            l = 8'($urandom_range(0, 255));
            send_frame(c, h, l, c ^ h ^ l);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_q.size() != 3) begin
            miscompares++; $display("FAIL b2b_events: got %0d want 3", obs_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                vectors++;
                if (obs_t_q[i] - obs_t_q[i-1] != 5 * CLK_P) begin miscompares++; $display("FAIL b2b_spacing: got %0t want %0d", obs_t_q[i] - obs_t_q[i-1], 5 * CLK_P); end
            end
        end
        t0 = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL b2b_event: got %h want %h", o, e); end
        end
        vectors++; if (frame_cnt_o !== 16'd3) begin miscompares++; $display("FAIL b2b_cnt: got %0d want 3", frame_cnt_o); end
        exp_q.delete(); obs_q.delete(); obs_t_q.delete();
    endtask

    task automatic test_random();
        logic [EW-1:0] e, o;
        logic [7:0] c, h, l, s;
        for (int i = 0; i < 16; i++) begin
            c = 8'($urandom_range(0, 7));
            h = 8'($urandom_range(0, 255));
            l = 8'($urandom_range(0, 255));
            s = c ^ h ^ l;
            if ($urandom_range(0, 2) == 0) s = s ^ 8'($urandom_range(1, 255));
            send_frame(c, h, l, s);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand_events: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL rand_event: got %h want %h", o, e); end
        end
        vectors++; if ({tr_chn_o, tr_data_o} !== {exp_chn, exp_data}) begin miscompares++; $display("FAIL rand_hold: got %0d/%h want %0d/%h", tr_chn_o, tr_data_o, exp_chn, exp_data); end
        vectors++; if (frame_cnt_o !== exp_cnt) begin miscompares++; $display("FAIL rand_cnt: got %0d want %0d", frame_cnt_o, exp_cnt); end
        exp_q.delete(); obs_q.delete(); obs_t_q.delete();
    endtask

    task automatic test_wrap();
        logic [EW-1:0] e, o;
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        exp_cnt = 16'hFFFF;
        @(negedge clk);
        vectors++; if (frame_cnt_o !== exp_cnt) begin miscompares++; $display("FAIL wrap_preload: got %h want ffff", frame_cnt_o); end
        send_frame(8'h01, 8'hBE, 8'hEF, 8'h01 ^ 8'hBE ^ 8'hEF);
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin miscompares++; $display("FAIL wrap_event: got %h want %h", o, e); end
        end
        vectors++; if (frame_cnt_o !== 16'h0000) begin miscompares++; $display("FAIL wrap_cnt: got %h want 0000", frame_cnt_o); end
        exp_q.delete(); obs_q.delete(); obs_t_q.delete();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_bad_chn_resync();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
